// File: rtl/aes_pkg.sv
// Constants and helpers for the AES-128 datapaths, shared by the encrypt and decrypt controllers.
// The GF(2^8) arithmetic uses the reduction polynomial 0x11B.
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FIN} state_t;

  localparam logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] inv_sbox [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  localparam logic [7:0] rcon [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round. Byte n of the block sits at [127-8n -: 8].
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] ark [16];

  always_comb begin
    ark       = '{default: 8'h00};
    state_out = '0;
    // Row r rotates right by r, so output (r,c) takes input (r,c-r); byte index is 4*col+row.
    for (int i = 0; i < 16; i++) begin
      ark[i] = inv_sbox[state_in[127 - 8*(4*(((i/4) - (i%4)) & 3) + (i%4)) -: 8]]
               ^ round_key[127 - 8*i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        state_out[127 - 32*c -: 32] = {ark[4*c], ark[4*c+1], ark[4*c+2], ark[4*c+3]};
      end else begin
        state_out[127 - 32*c -: 32] = {
          gf_mul(ark[4*c], 8'h0e) ^ gf_mul(ark[4*c+1], 8'h0b) ^ gf_mul(ark[4*c+2], 8'h0d) ^ gf_mul(ark[4*c+3], 8'h09),
          gf_mul(ark[4*c], 8'h09) ^ gf_mul(ark[4*c+1], 8'h0e) ^ gf_mul(ark[4*c+2], 8'h0b) ^ gf_mul(ark[4*c+3], 8'h0d),
          gf_mul(ark[4*c], 8'h0d) ^ gf_mul(ark[4*c+1], 8'h09) ^ gf_mul(ark[4*c+2], 8'h0e) ^ gf_mul(ark[4*c+3], 8'h0b),
          gf_mul(ark[4*c], 8'h0b) ^ gf_mul(ark[4*c+1], 8'h0d) ^ gf_mul(ark[4*c+2], 8'h09) ^ gf_mul(ark[4*c+3], 8'h0e)
        };
      end
    end
  end

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 inverse cipher: expands the key schedule once per block, then runs
// ten inverse rounds one per clock and reports the plaintext with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start; result from the previous block held
// KEYEXP | derives rk[rnd] from rk[rnd-1], rnd = 1..10
// ADDKEY | whitening with rk10, loads rnd = 9
// ROUND  | one inverse round per cycle, rnd counts 9 down to 0
// FIN    | done pulse, plain_text valid
module aes_decrypt_top
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_text,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         done,
  output logic [9:0]   completed_round,
  output logic [127:0] plain_text
);

  state_t       state, state_next;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] rk [11];
  logic [127:0] prev_rk, next_rk;
  logic [31:0]  t_word;
  logic [127:0] round_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = KEYEXP;
      KEYEXP:  if (rnd == 4'd10) state_next = ADDKEY;
      ADDKEY:  state_next = ROUND;
      ROUND:   if (rnd == 4'd0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prev_rk          = rk[rnd - 4'd1];
    t_word           = sub_word({prev_rk[23:0], prev_rk[31:24]}) ^ {rcon[rnd - 4'd1], 24'h000000};
    next_rk[127:96]  = prev_rk[127:96] ^ t_word;
    next_rk[95:64]   = prev_rk[95:64]  ^ next_rk[127:96];
    next_rk[63:32]   = prev_rk[63:32]  ^ next_rk[95:64];
    next_rk[31:0]    = prev_rk[31:0]   ^ next_rk[63:32];
  end

  aes_inv_round u_inv_round (
    .state_in  (st),
    .round_key (rk[rnd]),
    .last      (rnd == 4'd0),
    .state_out (round_out)
  );

  // Working state and key file carry no reset: nothing reaches an output before being reloaded.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        st    <= cipher_text;
        rk[0] <= cipher_key;
      end
      KEYEXP:  rk[rnd] <= next_rk;
      ADDKEY:  st <= st ^ rk[10];
      ROUND:   st <= round_out;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      completed_round <= '0;
      plain_text      <= '0;
      rnd             <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == ROUND) && (rnd == 4'd0);
      case (state)
        IDLE: if (start) begin
          completed_round <= '0;
          plain_text      <= '0;
          rnd             <= 4'd1;
        end
        KEYEXP: rnd <= rnd + 4'd1;
        ADDKEY: rnd <= 4'd9;
        ROUND: begin
          completed_round <= {completed_round[8:0], 1'b1};
          rnd             <= rnd - 4'd1;
          if (rnd == 4'd0) plain_text <= round_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Directed bench for aes_decrypt_top using FIPS-197 and SP800-38A vectors; checks latency,
// round progress, ignored start, abort by reset and back-to-back operation.
module tb_aes_decrypt_top;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cipher_text = '0;
  logic [127:0] cipher_key = '0;
  logic         busy, done;
  logic [9:0]   completed_round;
  logic [127:0] plain_text;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_E  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_E  = 128'h6bc1bee22e409f96e93d7e117393172a;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int cyc = 0;

  aes_decrypt_top dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cipher_text     (cipher_text),
    .cipher_key      (cipher_key),
    .busy            (busy),
    .done            (done),
    .completed_round (completed_round),
    .plain_text      (plain_text)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Entered #1 after an edge with the DUT idle; returns #1 after E22.
  task automatic run_op(input string tag, input logic [127:0] key, input logic [127:0] ct,
                        input logic [127:0] pt, input bit chk_cr, input bit glitch);
    int d0;
    cipher_key  = key;
    cipher_text = ct;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    chk({tag, "_busy_acc"}, busy, 1'b1);
    for (int j = 1; j <= 21; j++) begin
      if (glitch && (j == 5 || j == 15)) begin
        start       = 1'b1;
        cipher_key  = ~key;
        cipher_text = ~ct;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (chk_cr && j >= 11) chk($sformatf("%s_cr_E%0d", tag, j), completed_round, (1 << (j - 11)) - 1);
      if (j == 20) chk({tag, "_done_early"}, done, 1'b0);
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_pt"}, plain_text, pt);
    @(posedge clk); #1;
    chk({tag, "_done_off"}, done, 1'b0);
    chk({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_one_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0, t1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cr", completed_round, 10'h000);
    chk("rst_pt", plain_text, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("appb", KEY_B, CT_B, PT_B, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("appb_held", plain_text, PT_B);

    run_op("c1", KEY_C, CT_C, PT_C, 1'b1, 1'b0);
    run_op("glitch", KEY_B, CT_B, PT_B, 1'b0, 1'b1);

    // Abort with reset sampled at E14.
    cipher_key  = KEY_B;
    cipher_text = CT_B;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (13) @(posedge clk);
    #1;
    chk("abort_cr_E13", completed_round, 10'h003);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_cr", completed_round, 10'h000);
    chk("abort_pt", plain_text, 128'h0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    run_op("after_rst", KEY_B, CT_B, PT_B, 1'b0, 1'b0);

    // start held high across two blocks.
    cipher_key  = KEY_B;
    cipher_text = CT_B;
    start       = 1'b1;
    @(posedge clk); #1;
    cipher_text = CT_E;
    repeat (21) @(posedge clk);
    #1;
    chk("held1_done", done, 1'b1);
    chk("held1_pt", plain_text, PT_B);
    t1 = cyc;
    @(posedge clk); #1;
    chk("held_idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("held_reaccept", busy, 1'b1);
    chk("held_pt_clr", plain_text, 128'h0);
    repeat (21) @(posedge clk);
    #1;
    chk("held2_done", done, 1'b1);
    chk("held2_pt", plain_text, PT_E);
    chk("held_spacing", cyc - t1, 23);
    start = 1'b0;
    @(posedge clk); #1;
    chk("held_end_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
